// File: rtl/led_pattern_pkg.sv
// rtl/led_pattern_pkg.sv - shared mode encoding and sizing helper for the LED pattern driver
package led_pattern_pkg;

  typedef logic [1:0] mode_t;

  localparam mode_t MODE_OFF   = 2'd0;
  localparam mode_t MODE_ON    = 2'd1;
  localparam mode_t MODE_BLINK = 2'd2;
  localparam mode_t MODE_PWM   = 2'd3;

  // Channel-select width; a single channel still gets a 1-bit select port.
  function automatic int ch_bits(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/led_pattern_channel.sv
// rtl/led_pattern_channel.sv - one LED channel: mode/value registers, blink counter and phase, led flop
module led_pattern_channel
  import led_pattern_pkg::*;
#(
  parameter int                   CNT_BITS    = 16,
  parameter int                   PWM_BITS    = 4,
  parameter mode_t                RESET_MODE  = MODE_BLINK,
  parameter logic [CNT_BITS-1:0]  RESET_VALUE = CNT_BITS'(250)
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                tick,
  input  logic [PWM_BITS-1:0] pwm_cnt,
  input  logic                wr_en,
  input  mode_t               mode,
  input  logic [CNT_BITS-1:0] value,
  output logic                led
);

  mode_t               mode_q;
  logic [CNT_BITS-1:0] value_q;
  logic [CNT_BITS-1:0] cnt_q;
  logic                phase_q;
  logic                led_next;

  always_comb begin
    led_next = 1'b0;
    case (mode_q)
      MODE_OFF:   led_next = 1'b0;
      MODE_ON:    led_next = 1'b1;
      MODE_BLINK: led_next = phase_q;
      MODE_PWM:   led_next = (pwm_cnt < value_q[PWM_BITS-1:0]);
      default:    led_next = 1'b0;
    endcase
  end

  // A write always wins over a coincident tick so software can resync phases.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mode_q  <= RESET_MODE;
      value_q <= RESET_VALUE;
      cnt_q   <= '0;
      phase_q <= 1'b0;
      led     <= 1'b0;
    end else begin
      if (wr_en) begin
        mode_q  <= mode;
        value_q <= value;
        cnt_q   <= '0;
        phase_q <= 1'b0;
      end else if (tick && (mode_q == MODE_BLINK)) begin
        if (cnt_q == value_q) begin
          cnt_q   <= '0;
          phase_q <= ~phase_q;
        end else begin
          cnt_q   <= cnt_q + CNT_BITS'(1);
        end
      end
      led <= led_next;
    end
  end

endmodule

// File: rtl/led_pattern_driver.sv
// rtl/led_pattern_driver.sv - multi-channel LED driver: shared prescaler, PWM counter and write decode
module led_pattern_driver
  import led_pattern_pkg::*;
#(
  parameter int                  CHANNELS    = 2,
  parameter int                  PRESCALE    = 50_000,
  parameter int                  CNT_BITS    = 16,
  parameter int                  PWM_BITS    = 4,
  parameter mode_t               RESET_MODE  = MODE_BLINK,
  parameter logic [CNT_BITS-1:0] RESET_VALUE = CNT_BITS'(250),
  localparam int                 CH_BITS     = ch_bits(CHANNELS)
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                cfg_wr,
  input  logic [CH_BITS-1:0]  cfg_ch,
  input  mode_t               cfg_mode,
  input  logic [CNT_BITS-1:0] cfg_value,
  output logic                tick,
  output logic [CHANNELS-1:0] led
);

  localparam int                 PS_BITS = $clog2(PRESCALE);
  localparam logic [PS_BITS-1:0] PS_LAST = PS_BITS'(PRESCALE - 1);

  logic [PS_BITS-1:0]  presc;
  logic [PWM_BITS-1:0] pwm_cnt;
  logic [CHANNELS-1:0] wr_en;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      presc   <= '0;
      tick    <= 1'b0;
      pwm_cnt <= '0;
    end else begin
      tick    <= (presc == PS_LAST);
      presc   <= (presc == PS_LAST) ? '0 : presc + PS_BITS'(1);
      pwm_cnt <= pwm_cnt + PWM_BITS'(1);
    end
  end

  // Selects at or above CHANNELS match no instance, so such writes are dropped.
  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    assign wr_en[i] = cfg_wr && (cfg_ch == CH_BITS'(i));

    led_pattern_channel #(
      .CNT_BITS    (CNT_BITS),
      .PWM_BITS    (PWM_BITS),
      .RESET_MODE  (RESET_MODE),
      .RESET_VALUE (RESET_VALUE)
    ) u_ch (
      .clk     (clk),
      .reset_n (reset_n),
      .tick    (tick),
      .pwm_cnt (pwm_cnt),
      .wr_en   (wr_en[i]),
      .mode    (cfg_mode),
      .value   (cfg_value),
      .led     (led[i])
    );
  end

endmodule
